rf_riscv_sb: RTL and testbench

//  Parametrised RISC-V integer register file with an integrated write-pending scoreboard.

---
 rtl/rf_riscv_sb.sv | 77 +++++++
 tb/tb_rf_riscv_sb.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/rf_riscv_sb.sv
// RISC-V integer register file with per-register write-pending scoreboard.
// Optional same-cycle write-through to the read ports when RF_BYPASS_EN is defined.
module rf_riscv_sb #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         write_enable_i,
  input  logic [$clog2(NREGS)-1:0]     write_addr_i,
  input  logic [XLEN-1:0]              write_data_i,
  input  logic [NREAD*$clog2(NREGS)-1:0] read_addr_i,
  output logic [NREAD*XLEN-1:0]        read_data_o,
  output logic [NREAD-1:0]             read_busy_o,
  input  logic                         reserve_i,
  input  logic [$clog2(NREGS)-1:0]     reserve_addr_i,
  output logic [NREGS-1:0]             busy_vec_o,
  output logic                         any_busy_o
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;

  logic             w_wr_ok;
  logic             w_res_ok;
  logic [NREGS-1:0] w_set;
  logic [NREGS-1:0] w_clr;
  logic [AW-1:0]    w_ra [NREAD];

  always_comb begin
    w_wr_ok  = write_enable_i && !((ZERO_REG != 0) && (write_addr_i == '0));
    w_res_ok = reserve_i && !((ZERO_REG != 0) && (reserve_addr_i == '0));
    w_set    = w_res_ok ? (NREGS'(1) << reserve_addr_i) : '0;
    w_clr    = w_wr_ok ? (NREGS'(1) << write_addr_i) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[write_addr_i] <= write_data_i;
      // A new reservation wins over the release from an older producer.
      r_busy <= w_set | (r_busy & ~w_clr);
    end
  end

  always_comb begin
    read_data_o = '0;
    read_busy_o = '0;
    for (int unsigned k = 0; k < NREAD; k++) begin
      w_ra[k] = read_addr_i[k*AW +: AW];
      if ((ZERO_REG != 0) && (w_ra[k] == '0)) begin
        read_data_o[k*XLEN +: XLEN] = '0;
        read_busy_o[k]              = 1'b0;
      end else begin
        read_data_o[k*XLEN +: XLEN] = r_regs[w_ra[k]];
        read_busy_o[k]              = r_busy[w_ra[k]];
`ifdef RF_BYPASS_EN
        // Gated by rst_ni so reads stay 0 while reset is held.
        if (rst_ni && w_wr_ok && (write_addr_i == w_ra[k])) begin
          read_data_o[k*XLEN +: XLEN] = write_data_i;
          read_busy_o[k]              = 1'b0;
        end
`endif
      end
    end
  end

  assign busy_vec_o = r_busy;
  assign any_busy_o = |r_busy;

endmodule

// File: tb/tb_rf_riscv_sb.sv
// Scoreboard bench for rf_riscv_sb: the driver queues expected outputs, a negedge monitor checks them.
module tb_rf_riscv_sb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        write_enable_i = 1'b0;
  logic [4:0]  write_addr_i = '0;
  logic [31:0] write_data_i = '0;
  logic [9:0]  read_addr_i = '0;
  logic [63:0] read_data_o;
  logic [1:0]  read_busy_o;
  logic        reserve_i = 1'b0;
  logic [4:0]  reserve_addr_i = '0;
  logic [31:0] busy_vec_o;
  logic        any_busy_o;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_riscv_sb #(.XLEN(32), .NREGS(32), .NREAD(2), .ZERO_REG(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .write_enable_i(write_enable_i), .write_addr_i(write_addr_i), .write_data_i(write_data_i),
    .read_addr_i(read_addr_i), .read_data_o(read_data_o), .read_busy_o(read_busy_o),
    .reserve_i(reserve_i), .reserve_addr_i(reserve_addr_i),
    .busy_vec_o(busy_vec_o), .any_busy_o(any_busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic [31:0] vec;
    logic        any;
  } exp_t;

  exp_t q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  always @(negedge clk_i) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".d0"},  read_data_o[31:0],  e.d0);
      chk({e.name, ".d1"},  read_data_o[63:32], e.d1);
      chk({e.name, ".busy"}, {30'd0, read_busy_o}, {30'd0, e.b});
      chk({e.name, ".vec"}, busy_vec_o, e.vec);
      chk({e.name, ".any"}, {31'd0, any_busy_o}, {31'd0, e.any});
    end
  end

  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic res, input logic [4:0] rsa,
                     input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk_i);
    #1;
    write_enable_i = we;
    write_addr_i   = wa;
    write_data_i   = wd;
    reserve_i      = res;
    reserve_addr_i = rsa;
    read_addr_i    = {a1, a0};
  endtask

  task automatic push_exp(input string nm, input logic [31:0] d0, input logic [31:0] d1,
                          input logic [1:0] b, input logic [31:0] vec, input logic any);
    exp_t e;
    e.name = nm; e.d0 = d0; e.d1 = d1; e.b = b; e.vec = vec; e.any = any;
    q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    cyc(0, 0, 0, 0, 0, 5, 0);
    push_exp("reset_state", 0, 0, 2'b00, 0, 0);

    // x5 written and reserved on the same edge, then asynchronous reset mid-cycle
    cyc(1, 5, 32'hDEADBEEF, 1, 5, 0, 0);
    push_exp("pre_write", 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 5, 5);
    push_exp("x5_written", 32'hDEADBEEF, 32'hDEADBEEF, 2'b11, 32'h20, 1);
    cyc(0, 0, 0, 0, 0, 5, 5);
    rst_ni = 1'b0;
    #1;
    push_exp("async_reset", 0, 0, 2'b00, 0, 0);
    @(negedge clk_i);
    #1;
    rst_ni = 1'b1;

    // x0 is hardwired
    cyc(1, 0, 32'h12345678, 1, 0, 0, 0);
    push_exp("x0_same", 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    push_exp("x0_after", 0, 0, 2'b00, 0, 0);

    // write then read on both ports
    cyc(1, 7, 32'hA5A5A5A5, 0, 0, 0, 0);
    push_exp("x7_wr", 0, 0, 2'b00, 0, 0);
    cyc(0, 0, 0, 0, 0, 7, 7);
    push_exp("x7_read", 32'hA5A5A5A5, 32'hA5A5A5A5, 2'b00, 0, 0);

    // reserve / release x3
    cyc(0, 0, 0, 1, 3, 3, 7);
    push_exp("x3_res", 0, 32'hA5A5A5A5, 2'b00, 0, 0);
    cyc(1, 3, 32'h11, 0, 0, 3, 7);
    push_exp("x3_wr", BYP ? 32'h11 : 32'h0, 32'hA5A5A5A5, BYP ? 2'b00 : 2'b01, 32'h8, 1);
    cyc(0, 0, 0, 0, 0, 3, 7);
    push_exp("x3_done", 32'h11, 32'hA5A5A5A5, 2'b00, 0, 0);

    // reserve and write x9 on the same edge: busy stays set
    cyc(0, 0, 0, 1, 9, 9, 3);
    push_exp("x9_res", 0, 32'h11, 2'b00, 0, 0);
    cyc(1, 9, 32'h22, 1, 9, 3, 7);
    push_exp("x9_coll", 32'h11, 32'hA5A5A5A5, 2'b00, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 9, 3);
    push_exp("x9_after", 32'h22, 32'h11, 2'b01, 32'h200, 1);

    // same-cycle read of the register being written
    cyc(1, 4, 32'h55, 0, 0, 4, 9);
    push_exp("x4_bypass", BYP ? 32'h55 : 32'h0, 32'h22, 2'b10, 32'h200, 1);
    cyc(1, 9, 32'h33, 0, 0, 4, 9);
    push_exp("x9_release", 32'h55, BYP ? 32'h33 : 32'h22, BYP ? 2'b00 : 2'b10, 32'h200, 1);
    cyc(0, 0, 0, 0, 0, 9, 4);
    push_exp("final", 32'h33, 32'h55, 2'b00, 0, 0);

    repeat (2) @(posedge clk_i);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
